disp_scan_ctrl: RTL and testbench

Time-multiplexing scan driver for the 8-digit 7-segment display. Generates the 3-bit digit select that drives the 8:1 nibble mux and takes the selected nibble back. Hex-decodes that nibble to segments and drives the active-low anodes. Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/disp_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan driver for an 8-digit 7-segment display.
// Each digit slot is CLK_DIV cycles: BLANK_CYCLES with all anodes off, then the
// selected digit lit. The decoded segments and anode are latched at the
// BLANK->DISPLAY edge and held for the rest of the slot.
// Optional macro DISP_SCAN_DP_EN adds a per-digit decimal point (dp_mask / dp).
module disp_scan_ctrl #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16,
   parameter int N_DIGITS     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] digit_mask,
   input  logic [3:0] digit,
`ifdef DISP_SCAN_DP_EN
   input  logic [7:0] dp_mask,
   output logic       dp,
`endif
   output logic [2:0] sel,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       frame_start
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DISP_LAST  = CW'(CLK_DIV - BLANK_CYCLES - 1);
   localparam logic [2:0]    SEL_LAST   = 3'(N_DIGITS - 1);

   typedef enum logic {BLANK, DISPLAY} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    sel_nx;
   logic [7:0]    an_nx;
   logic [6:0]    seg_nx;
   logic          fs_nx;
   logic          lit;
`ifdef DISP_SCAN_DP_EN
   logic          dp_nx;
`endif

   // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // A digit lights only when the display is enabled and the digit is not masked.
   assign lit = en && digit_mask[sel];

   // State, counter and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BLANK;
         cnt         <= '0;
         sel         <= 3'd0;
         an          <= 8'hFF;
         seg         <= 7'h7F;
         frame_start <= 1'b0;
`ifdef DISP_SCAN_DP_EN
         dp          <= 1'b1;
`endif
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         sel         <= sel_nx;
         an          <= an_nx;
         seg         <= seg_nx;
         frame_start <= fs_nx;
`ifdef DISP_SCAN_DP_EN
         dp          <= dp_nx;
`endif
      end
   end

   // Next-state logic: blank gap, latch digit, hold, then advance the select.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      sel_nx   = sel;
      an_nx    = an;
      seg_nx   = seg;
      fs_nx    = 1'b0;
`ifdef DISP_SCAN_DP_EN
      dp_nx    = dp;
`endif
      case (state)
         BLANK: begin
            an_nx  = 8'hFF;
            seg_nx = 7'h7F;
`ifdef DISP_SCAN_DP_EN
            dp_nx  = 1'b1;
`endif
            if (cnt == BLANK_LAST) begin
               seg_nx   = hex7(digit);
               an_nx    = lit ? ~(8'b1 << sel) : 8'hFF;
`ifdef DISP_SCAN_DP_EN
               dp_nx    = lit ? ~dp_mask[sel] : 1'b1;
`endif
               cnt_nx   = '0;
               state_nx = DISPLAY;
            end
         end
         default: begin
            if (cnt == DISP_LAST) begin
               an_nx    = 8'hFF;
               seg_nx   = 7'h7F;
`ifdef DISP_SCAN_DP_EN
               dp_nx    = 1'b1;
`endif
               sel_nx   = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
               fs_nx    = (sel == SEL_LAST);
               cnt_nx   = '0;
               state_nx = BLANK;
            end
         end
      endcase
      // Disable blanks the outputs immediately but leaves the scan timing running;
      // the display comes back only at the next latch edge.
      if (!en) begin
         an_nx  = 8'hFF;
         seg_nx = 7'h7F;
`ifdef DISP_SCAN_DP_EN
         dp_nx  = 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2, N_DIGITS=8).
// The reference model works from elapsed cycles since reset: slot = k/CLK_DIV,
// position = k%CLK_DIV, and a digit lights at position BLANK_CYCLES.
module tb_disp_scan_ctrl;
   localparam int CD = 8;
   localparam int BL = 2;
   localparam int ND = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic [7:0] digit_mask = 8'hFF;
   logic [3:0] digit;
   logic [2:0] sel;
   logic [7:0] an;
   logic [6:0] seg;
   logic       frame_start;
   logic [7:0] dp_mask = 8'h04;
`ifdef DISP_SCAN_DP_EN
   logic       dp;
`endif

   logic [3:0] mux [8];
   logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int chk_cnt = 0;
   int pass_cnt = 0;

   // model state
   int         k = 0;
   logic       m_lit = 1'b0;
   logic [6:0] m_seg = 7'h7F;
   logic       m_dp = 1'b1;
   logic [7:0] exp_an;
   logic [6:0] exp_seg;
   logic [2:0] exp_sel;
   logic       exp_fs;
   logic       exp_dp;
   logic       seg_chk;

   disp_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BL), .N_DIGITS(ND)) dut (
      .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask), .digit(digit),
`ifdef DISP_SCAN_DP_EN
      .dp_mask(dp_mask), .dp(dp),
`endif
      .sel(sel), .an(an), .seg(seg), .frame_start(frame_start));

   always #5 clk = ~clk;
   assign digit = mux[sel];

   // Advance one clock, sample 1 time unit later, and update the timeline model.
   task automatic tick();
      int p, s;
      @(posedge clk);
      #1;
      if (reset) begin
         k = 0; m_lit = 1'b0;
      end else begin
         k++;
         p = k % CD;
         s = (k / CD) % ND;
         if (p == BL) begin
            m_lit = en && digit_mask[s];
            m_seg = HEX[mux[s]];
            m_dp  = ~dp_mask[s];
         end else if (!en || p < BL) begin
            m_lit = 1'b0;
         end
      end
      p       = k % CD;
      exp_sel = 3'((k / CD) % ND);
      exp_an  = m_lit ? ~(8'b1 << exp_sel) : 8'hFF;
      exp_fs  = (p == 0) && (k > 0) && (exp_sel == 3'd0);
      exp_dp  = m_lit ? m_dp : 1'b1;
      seg_chk = (p < BL) || (k > 0 && !en) || m_lit;
      exp_seg = m_lit ? m_seg : 7'h7F;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      chk_cnt++; if (an !== 8'hFF) $display("FAIL reset_an got=%h exp=ff", an); else pass_cnt++;
      chk_cnt++; if (seg !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", seg); else pass_cnt++;
      chk_cnt++; if (sel !== 3'd0) $display("FAIL reset_sel got=%0d exp=0", sel); else pass_cnt++;
      chk_cnt++; if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b exp=0", frame_start); else pass_cnt++;
   endtask

   task automatic test_timing();
      for (int i = 0; i < 8; i++) mux[i] = 4'(i);
      mux[0] = 4'h3;
      reset = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c <= 1 || c == 8) begin
            chk_cnt++; if (an !== 8'hFF) $display("FAIL timing_blank_an c=%0d got=%h exp=ff", c, an); else pass_cnt++;
         end else if (c <= 7) begin
            chk_cnt++; if (an !== 8'hFE) $display("FAIL timing_lit_an c=%0d got=%h exp=fe", c, an); else pass_cnt++;
            chk_cnt++; if (seg !== 7'b0110000) $display("FAIL timing_seg c=%0d got=%b exp=0110000", c, seg); else pass_cnt++;
         end
         chk_cnt++; if (sel !== exp_sel) $display("FAIL timing_sel c=%0d got=%0d exp=%0d", c, sel, exp_sel); else pass_cnt++;
      end
   endtask

   task automatic test_full_frame();
      int pulses = 0;
      for (int i = 0; i < 8; i++) mux[i] = 4'(i + 8);
      for (int c = 0; c < 64; c++) begin
         tick();
         if (frame_start) pulses++;
         chk_cnt++; if (an !== exp_an) $display("FAIL frame_an k=%0d got=%h exp=%h", k, an, exp_an); else pass_cnt++;
         chk_cnt++; if (sel !== exp_sel) $display("FAIL frame_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); else pass_cnt++;
         chk_cnt++; if (frame_start !== exp_fs) $display("FAIL frame_fs k=%0d got=%b exp=%b", k, frame_start, exp_fs); else pass_cnt++;
         if (seg_chk) begin
            chk_cnt++; if (seg !== exp_seg) $display("FAIL frame_seg k=%0d got=%b exp=%b", k, seg, exp_seg); else pass_cnt++;
         end
      end
      chk_cnt++; if (pulses != 1) $display("FAIL frame_pulse_count got=%0d exp=1", pulses); else pass_cnt++;
   endtask

   task automatic test_mask();
      digit_mask = 8'b1111_0101;
      for (int c = 0; c < 72; c++) begin
         tick();
         chk_cnt++; if (an !== exp_an) $display("FAIL mask_an k=%0d got=%h exp=%h", k, an, exp_an); else pass_cnt++;
         chk_cnt++; if (sel !== exp_sel) $display("FAIL mask_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); else pass_cnt++;
         if (seg_chk) begin
            chk_cnt++; if (seg !== exp_seg) $display("FAIL mask_seg k=%0d got=%b exp=%b", k, seg, exp_seg); else pass_cnt++;
         end
      end
      digit_mask = 8'hFF;
   endtask

   task automatic test_enable();
      bit found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (exp_sel == 3'd2 && (k % CD) == BL + 2) found = 1;
      end
      chk_cnt++; if (!found) $display("FAIL enable_sync got=timeout exp=sel2_display"); else pass_cnt++;
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_cnt++; if (an !== 8'hFF) $display("FAIL enable_off_an got=%h exp=ff", an); else pass_cnt++;
         chk_cnt++; if (seg !== 7'h7F) $display("FAIL enable_off_seg got=%b exp=7f", seg); else pass_cnt++;
         chk_cnt++; if (sel !== exp_sel) $display("FAIL enable_off_sel got=%0d exp=%0d", sel, exp_sel); else pass_cnt++;
      end
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         tick();
         chk_cnt++; if (an !== exp_an) $display("FAIL enable_on_an k=%0d got=%h exp=%h", k, an, exp_an); else pass_cnt++;
         chk_cnt++; if (sel !== exp_sel) $display("FAIL enable_on_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); else pass_cnt++;
         if (seg_chk) begin
            chk_cnt++; if (seg !== exp_seg) $display("FAIL enable_on_seg k=%0d got=%b exp=%b", k, seg, exp_seg); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         tick();
         if (exp_sel == 3'd5 && (k % CD) == BL + 1) found = 1;
      end
      chk_cnt++; if (!found) $display("FAIL rstmid_sync got=timeout exp=sel5_display"); else pass_cnt++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_cnt++; if (sel !== 3'd0) $display("FAIL rstmid_sel got=%0d exp=0", sel); else pass_cnt++;
      chk_cnt++; if (an !== 8'hFF) $display("FAIL rstmid_an got=%h exp=ff", an); else pass_cnt++;
      chk_cnt++; if (seg !== 7'h7F) $display("FAIL rstmid_seg got=%b exp=7f", seg); else pass_cnt++;
      tick();
      chk_cnt++; if (an !== 8'hFF) $display("FAIL rstmid_blank got=%h exp=ff", an); else pass_cnt++;
      tick();
      chk_cnt++; if (an !== 8'hFE) $display("FAIL rstmid_first_lit got=%h exp=fe", an); else pass_cnt++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 320; c++) begin
         if ($urandom_range(0, 9) == 0) en = ~en;
         if ($urandom_range(0, 31) == 0) digit_mask = 8'($urandom);
         if ($urandom_range(0, 31) == 0) dp_mask = 8'($urandom);
         mux[$urandom_range(0, 7)] = 4'($urandom);
         tick();
         chk_cnt++; if (an !== exp_an) $display("FAIL rand_an k=%0d got=%h exp=%h", k, an, exp_an); else pass_cnt++;
         chk_cnt++; if (sel !== exp_sel) $display("FAIL rand_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); else pass_cnt++;
         chk_cnt++; if (frame_start !== exp_fs) $display("FAIL rand_fs k=%0d got=%b exp=%b", k, frame_start, exp_fs); else pass_cnt++;
         if (seg_chk) begin
            chk_cnt++; if (seg !== exp_seg) $display("FAIL rand_seg k=%0d got=%b exp=%b", k, seg, exp_seg); else pass_cnt++;
         end
`ifdef DISP_SCAN_DP_EN
         chk_cnt++; if (dp !== exp_dp) $display("FAIL rand_dp k=%0d got=%b exp=%b", k, dp, exp_dp); else pass_cnt++;
`endif
      end
      en = 1'b1; digit_mask = 8'hFF;
   endtask

`ifdef DISP_SCAN_DP_EN
   task automatic test_dp();
      dp_mask = 8'h04;
      for (int c = 0; c < 64; c++) begin
         tick();
         chk_cnt++; if (dp !== exp_dp) $display("FAIL dp k=%0d got=%b exp=%b an=%h", k, dp, exp_dp, an); else pass_cnt++;
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) mux[i] = 4'h0;
      test_reset();
      test_timing();
      test_full_frame();
      test_mask();
      test_enable();
      test_reset_mid();
`ifdef DISP_SCAN_DP_EN
      test_dp();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
